// File: rtl/clkgen_pkg.sv
// Shared constants and the divider-limit helper for the clkgen programmable clock divider.
package clkgen_pkg;

    localparam int unsigned CLKIN_FREQ_HZ = 100_000_000;
    localparam int unsigned COUNT_W       = 32;

    // Half-period length in clkin cycles, minus one: the value the counter wraps at.
    function automatic logic [COUNT_W-1:0] count_limit(input int unsigned clkin_hz,
                                                       input int unsigned out_hz);
        int unsigned half_cycles;
        half_cycles = clkin_hz / (2 * out_hz);
        return COUNT_W'(half_cycles - 1);
    endfunction

endpackage

// File: rtl/clkgen_if.sv
// Consumer-facing signals of the clock divider: run/freeze request in, divided clock out.
interface clkgen_if;
    import clkgen_pkg::*;

    logic clken;
    logic clkout;

    modport master (output clken, input  clkout);
    modport slave  (input  clken, output clkout);

endinterface

// File: rtl/clkgen.sv
// Programmable 50 % duty clock divider; rst restarts the phase so the first rise lands half a period later.
module clkgen
    import clkgen_pkg::*;
#(
    parameter int unsigned clk_freq   = 1000,
    parameter int unsigned CLKIN_FREQ = CLKIN_FREQ_HZ
) (
    input  logic clkin,
    input  logic rst,
    input  logic clken,
    output logic clkout
);

    localparam logic [COUNT_W-1:0] COUNT_LIMIT = count_limit(CLKIN_FREQ, clk_freq);

    logic [COUNT_W-1:0] counter;

    // Reset beats enable; a frozen divider keeps both its partial count and its output level.
    always_ff @(posedge clkin) begin
        if (rst) begin
            counter <= '0;
            clkout  <= 1'b0;
        end else if (clken) begin
            if (counter == COUNT_LIMIT) begin
                counter <= '0;
                clkout  <= ~clkout;
            end else begin
                counter <= counter + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clkgen.sv
// Bench for clkgen: three divider instances checked every cycle against an edge-counting model.
module tb_clkgen;

    localparam longint A_L = 100000000 / (2 * 1000);
    localparam longint B_L = 100000000 / (2 * 115200);
    localparam longint C_L = 100000000 / (2 * 50000000);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst = 1'b1;
    logic b_rst = 1'b1;
    logic c_rst = 1'b1;

    clkgen_if a_if ();
    clkgen_if b_if ();
    clkgen_if c_if ();

    clkgen #(.clk_freq(1000)) u_a (
        .clkin(clk), .rst(a_rst), .clken(a_if.clken), .clkout(a_if.clkout)
    );
    clkgen #(.clk_freq(115200)) u_b (
        .clkin(clk), .rst(b_rst), .clken(b_if.clken), .clkout(b_if.clkout)
    );
    clkgen #(.clk_freq(50000000)) u_c (
        .clkin(clk), .rst(c_rst), .clken(c_if.clken), .clkout(c_if.clkout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: enabled edges since the last reset edge; output is that count divided into half periods.
    longint a_n, b_n, c_n;
    bit a_v = 0, b_v = 0, c_v = 0;
    int a_rst_cyc, b_rst_cyc, c_rst_cyc;

    function automatic logic model_out(longint n, longint half);
        return logic'((n / half) % 2);
    endfunction

    function automatic void check(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endfunction

    function automatic void check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (a_rst) begin a_n = 0; a_v = 1; a_rst_cyc = cyc; end
        else if (a_if.clken) a_n++;
        if (b_rst) begin b_n = 0; b_v = 1; b_rst_cyc = cyc; end
        else if (b_if.clken) b_n++;
        if (c_rst) begin c_n = 0; c_v = 1; c_rst_cyc = cyc; end
        else if (c_if.clken) c_n++;
        #1;
        if (a_v) check("a_clkout", a_if.clkout, model_out(a_n, A_L));
        if (b_v) check("b_clkout", b_if.clkout, model_out(b_n, B_L));
        if (c_v) check("c_clkout", c_if.clkout, model_out(c_n, C_L));
    end

    task automatic b_wait_level(input logic lvl, input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (b_if.clkout === lvl) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_wait_level timeout cycle %0d: clkout %b never reached %b", cyc, b_if.clkout, lvl);
        end
    endtask

    task automatic wait_until_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // 50 MHz instance: reset with enable high, then toggle every cycle, then random gating.
    initial begin
        c_if.clken = 1'b1;
        @(negedge clk);
        @(negedge clk);
        c_rst = 1'b0;
        check("c_after_reset", c_if.clkout, 1'b0);
        @(posedge clk); #1; check("c_edge1", c_if.clkout, 1'b1);
        @(posedge clk); #1; check("c_edge2", c_if.clkout, 1'b0);
        @(posedge clk); #1; check("c_edge3", c_if.clkout, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            c_if.clken = ($urandom_range(0, 3) != 0);
            c_rst      = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        c_rst = 1'b0;
        c_if.clken = 1'b1;
    end

    initial begin
        int t, r, f, prev;
        a_if.clken = 1'b1;
        b_if.clken = 1'b0;
        @(negedge clk);
        a_rst = 1'b0;

        // First-rise timing after a reset pulse at 115200.
        @(negedge clk);
        b_if.clken = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        check("b_reset_low", b_if.clkout, 1'b0);
        b_wait_level(1'b1, 1000, t);
        check_int("b_first_rise", t - b_rst_cyc, 434);
        b_wait_level(1'b0, 1000, f);
        check_int("b_first_fall", f - b_rst_cyc, 868);
        b_wait_level(1'b1, 1000, t);
        check_int("b_second_rise", t - b_rst_cyc, 1302);

        prev = t;
        for (int p = 0; p < 10; p++) begin
            b_wait_level(1'b0, 1000, f);
            check_int("b_high_time", f - prev, 434);
            b_wait_level(1'b1, 1000, t);
            check_int("b_period", t - prev, 868);
            prev = t;
        end

        // Freeze for 100 cycles at count 200 while high: fall slips by exactly 100.
        r = prev;
        wait_until_cyc(r + 200);
        @(negedge clk);
        b_if.clken = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check("b_freeze_hold", b_if.clkout, 1'b1);
        end
        @(negedge clk);
        b_if.clken = 1'b1;
        b_wait_level(1'b0, 1000, f);
        check_int("b_fall_after_freeze", f - r, 534);

        // Reset while high at count 300.
        b_wait_level(1'b1, 1000, r);
        wait_until_cyc(r + 300);
        check("b_high_before_rst", b_if.clkout, 1'b1);
        @(negedge clk);
        b_rst = 1'b1;
        @(posedge clk); #1;
        check("b_rst_mid_low", b_if.clkout, 1'b0);
        @(negedge clk);
        b_rst = 1'b0;
        b_wait_level(1'b1, 1000, t);
        check_int("b_rise_after_rst", t - b_rst_cyc, 434);

        // rst and clken both high for 5 cycles.
        @(negedge clk);
        b_rst = 1'b1;
        b_if.clken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("b_rst_wins", b_if.clkout, 1'b0);
        end
        @(negedge clk);
        b_rst = 1'b0;
        b_wait_level(1'b1, 1000, t);
        check_int("b_rise_after_long_rst", t - b_rst_cyc, 434);

        // Random gating and occasional resets, checked by the per-cycle model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            b_if.clken = ($urandom_range(0, 9) != 0);
            b_rst      = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        b_rst = 1'b0;
        b_if.clken = 1'b1;

        // Default 1 kHz instance: first rise 50000 cycles after its reset edge.
        wait_until_cyc(a_rst_cyc + 49999);
        check("a_low_before_rise", a_if.clkout, 1'b0);
        @(posedge clk); #1;
        check("a_first_rise", a_if.clkout, 1'b1);
        check_int("a_rise_delay", cyc - a_rst_cyc, 50000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clkgen.md
Name: clkgen

Overview:
- Programmable clock divider. Derives a 50 % duty-cycle square wave at frequency clk_freq from the 100 MHz system clock.
- Used by the serial receiver as its bit clock (instance overrides clk_freq to 115200).
- Synchronous reset restarts the divider phase so the first output rising edge lands half an output period after reset, i.e. mid-bit when reset is pulsed on a start-bit edge.
- Enable input freezes the divider when the consumer is idle.

Parameters:
- clk_freq, default 1000, desired output frequency in Hz; must satisfy 1 <= clk_freq <= CLKIN_FREQ/2.
- CLKIN_FREQ, default 100000000, frequency of clkin in Hz.
- Derived localparam COUNT_LIMIT = CLKIN_FREQ/(2*clk_freq) - 1, integer division truncating. For 115200 this is 433.

Ports:
- clkin  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- clken  input  1  count enable; high = run, low = freeze.
- clkout  output  1  divided clock, registered.

Behaviour:
- Single clock domain: clkin. Reset is synchronous and active-high on rst.
- State:
  - 32-bit counter, unsigned.
  - clkout register.
- Reset value: counter = 0, clkout = 0.
- Per rising edge of clkin, first matching rule wins:
  1. rst = 1: counter <= 0, clkout <= 0. Reset has priority over clken.
  2. clken = 0: counter and clkout hold their values. Output freezes at its current level; there is no glitch.
  3. counter == COUNT_LIMIT: counter <= 0, clkout <= ~clkout.
  4. Otherwise: counter <= counter + 1, clkout holds.
- Timing: if reset is sampled at edge k and clken stays high afterwards:
  - clkout first rises at edge k + COUNT_LIMIT + 1 (edge k+434 for 115200).
  - clkout then toggles every COUNT_LIMIT + 1 edges.
  - Period = 2*(COUNT_LIMIT + 1) clkin cycles (868 for 115200); high time = low time = COUNT_LIMIT + 1.
- COUNT_LIMIT = 0 (clk_freq = CLKIN_FREQ/2): clkout toggles every enabled cycle.
- Reset mid-operation: any phase is discarded immediately on that edge and the divider restarts from 0/low.
- Enable drop mid-period: the partial count is retained. Counting resumes where it left off when clken returns high.
- rst and clken both high on the same edge: reset wins. Counting starts on the next edge.
- Counter never exceeds COUNT_LIMIT; there is no wrap-around past the limit.
- clkout is a register output: no combinational path from any input.
- Consumers sample clkout through their own synchronizer. The block does not provide an edge strobe.

Decomposition:
- No shared package needed. COUNT_LIMIT is a local derived constant.
- No sub-modules; single flat module.

Test Plan:
- Default-param variant (clk_freq = 1000): rst pulse, clken = 1 -> clkout rises at 50000 cycles after reset, period 100000 cycles, 50 % duty.
- clk_freq = 115200: one-cycle rst pulse at edge k, clken = 1 -> clkout low through edge k+433, high at edge k+434, falls at k+868, rises at k+1302. Check 10 consecutive periods of 868 cycles.
- Enable gating (115200): drop clken for 100 cycles when counter = 200 while clkout = 1 -> clkout stays 1 during the freeze; next fall delayed by exactly 100 cycles.
- Reset mid-operation: assert rst while clkout = 1 and counter = 300 -> clkout = 0 on the next edge; next rise 434 cycles later.
- rst and clken both high for 5 cycles -> clkout held 0, counter held 0; first rise 434 cycles after rst deasserts.
- clk_freq = 50000000: enabled after reset -> clkout toggles every cycle, 0 then 1 then 0, period 2 cycles.
